// File: rtl/mdu_ctrl_if.sv
// Command/result bundle between E-stage control and the multiply/divide unit.
// Optional MDU_CANCEL_EN macro adds the cancel (pipeline flush) input.
interface mdu_ctrl_if;
    logic        start;
    logic [3:0]  hilo_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        md_use;
`ifdef MDU_CANCEL_EN
    logic        cancel;
`endif
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;
    logic        done;

`ifdef MDU_CANCEL_EN
    modport slave (input start, hilo_op, rs_val, rt_val, md_use, cancel,
                   output hi, lo, busy, stall, done);
    modport master (output start, hilo_op, rs_val, rt_val, md_use, cancel,
                    input hi, lo, busy, stall, done);
`else
    modport slave (input start, hilo_op, rs_val, rt_val, md_use,
                   output hi, lo, busy, stall, done);
    modport master (output start, hilo_op, rs_val, rt_val, md_use,
                    input hi, lo, busy, stall, done);
`endif
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller owning the architectural HI/LO registers.
// Results are computed at start into shadow registers and committed after a fixed
// busy countdown. Define MDU_CANCEL_EN to enable the cancel (flush) input.
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned CNT_W       = 4
) (
    input logic       clk,
    input logic       reset,
    mdu_ctrl_if.slave bus
);

    localparam logic [3:0] OpMult  = 4'b0110;
    localparam logic [3:0] OpMultu = 4'b0100;
    localparam logic [3:0] OpDiv   = 4'b0111;
    localparam logic [3:0] OpDivu  = 4'b0101;
    localparam logic [3:0] OpMthi  = 4'b0010;
    localparam logic [3:0] OpMtlo  = 4'b0011;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       hi_q, hi_d, lo_q, lo_d;
    logic [31:0]       shadow_hi_q, shadow_hi_d, shadow_lo_q, shadow_lo_d;
    logic              dz_q, dz_d;
    logic              done_q, done_d;
    logic              cancel_w;

    logic              div_ovf;
    logic [31:0]       div_rt_s, div_rt_u;
    logic [63:0]       prod_s, prod_u;
    logic [31:0]       quo_s, rem_s, quo_u, rem_u;

`ifdef MDU_CANCEL_EN
    assign cancel_w = bus.cancel;
`else
    assign cancel_w = 1'b0;
`endif

    // Arithmetic on the forwarded operands; divisors are forced to 1 where the
    // result is either discarded (divide by zero) or equals the dividend (INT_MIN / -1).
    always_comb begin
        div_ovf  = (bus.rs_val == 32'h8000_0000) && (bus.rt_val == 32'hFFFF_FFFF);
        div_rt_s = (bus.rt_val == 32'd0 || div_ovf) ? 32'd1 : bus.rt_val;
        div_rt_u = (bus.rt_val == 32'd0) ? 32'd1 : bus.rt_val;
        prod_s   = 64'($signed({{32{bus.rs_val[31]}}, bus.rs_val}) *
                       $signed({{32{bus.rt_val[31]}}, bus.rt_val}));
        prod_u   = {32'd0, bus.rs_val} * {32'd0, bus.rt_val};
        quo_s    = 32'($signed(bus.rs_val) / $signed(div_rt_s));
        rem_s    = 32'($signed(bus.rs_val) % $signed(div_rt_s));
        quo_u    = bus.rs_val / div_rt_u;
        rem_u    = bus.rs_val % div_rt_u;
    end

    // Next-state: accept start / mt writes in idle, count down and commit in run
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        shadow_hi_d = shadow_hi_q;
        shadow_lo_d = shadow_lo_q;
        dz_d        = dz_q;
        done_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start && !cancel_w) begin
                    case (bus.hilo_op)
                        OpMult, OpMultu: begin
                            {shadow_hi_d, shadow_lo_d} =
                                (bus.hilo_op == OpMult) ? prod_s : prod_u;
                            dz_d    = 1'b0;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            state_d = StRun;
                        end
                        OpDiv, OpDivu: begin
                            shadow_lo_d = (bus.hilo_op == OpDiv) ? quo_s : quo_u;
                            shadow_hi_d = (bus.hilo_op == OpDiv) ? rem_s : rem_u;
                            dz_d        = (bus.rt_val == 32'd0);
                            cnt_d       = CNT_W'(DIV_CYCLES);
                            state_d     = StRun;
                        end
                        default: ;
                    endcase
                end else if (!bus.start) begin
                    if (bus.hilo_op == OpMthi) hi_d = bus.rs_val;
                    if (bus.hilo_op == OpMtlo) lo_d = bus.rs_val;
                end
            end
            StRun: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cancel_w) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else if (cnt_q == CNT_W'(1)) begin
                    // Divide by zero still completes but leaves HI/LO untouched
                    if (!dz_q) begin
                        hi_d = shadow_hi_q;
                        lo_d = shadow_lo_q;
                    end
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            shadow_hi_q <= '0;
            shadow_lo_q <= '0;
            dz_q        <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            shadow_hi_q <= shadow_hi_d;
            shadow_lo_q <= shadow_lo_d;
            dz_q        <= dz_d;
            done_q      <= done_d;
        end
    end

    // The start instruction itself never stalls; only HI/LO users arriving while busy do
    assign bus.busy  = (state_q == StRun);
    assign bus.stall = bus.md_use & bus.busy;
    assign bus.done  = done_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases plus randomized operations
// checked against an arithmetic reference model of HI/LO.
module tb_mdu_ctrl;

    localparam logic [3:0] OP_MULT  = 4'b0110;
    localparam logic [3:0] OP_MULTU = 4'b0100;
    localparam logic [3:0] OP_DIV   = 4'b0111;
    localparam logic [3:0] OP_DIVU  = 4'b0101;
    localparam logic [3:0] OP_MTHI  = 4'b0010;
    localparam logic [3:0] OP_MTLO  = 4'b0011;
    localparam logic [3:0] OP_MFLO  = 4'b0001;
    localparam logic [3:0] OP_NONE  = 4'b0000;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [31:0] m_hi, m_lo;

    mdu_ctrl_if bus ();

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // A new start must never reach the unit while an operation is in flight
    assert property (@(posedge clk) disable iff (!reset) !(bus.start && bus.busy))
        else $error("FAIL start_while_busy: start=1 observed with busy=1, required no start");

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start   = 1'b0;
        bus.hilo_op = OP_NONE;
        bus.md_use  = 1'b0;
        bus.rs_val  = '0;
        bus.rt_val  = '0;
`ifdef MDU_CANCEL_EN
        bus.cancel  = 1'b0;
`endif
    endtask

    // Reference: {write_enable, hi, lo} from plain arithmetic on the operands
    function automatic logic [64:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, ma, mb, q, r;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            OP_MULT:  begin p = sa * sb; return {1'b1, p}; end
            OP_MULTU: begin p = ua * ub; return {1'b1, p}; end
            OP_DIV: begin
                if (b == 32'd0) return 65'd0;
                ma = (sa < 0) ? -sa : sa;
                mb = (sb < 0) ? -sb : sb;
                q  = ma / mb;
                if ((sa < 0) != (sb < 0)) q = -q;
                r  = sa - q * sb;
                return {1'b1, r[31:0], q[31:0]};
            end
            OP_DIVU: begin
                if (b == 32'd0) return 65'd0;
                return {1'b1, a % b, a / b};
            end
            default: return 65'd0;
        endcase
    endfunction

    task automatic mt_write(input logic to_hi, input logic [31:0] val);
        bus.start   = 1'b0;
        bus.md_use  = 1'b1;
        bus.hilo_op = to_hi ? OP_MTHI : OP_MTLO;
        bus.rs_val  = val;
        #1;
        check("mt_stall", {31'd0, bus.stall}, 32'd0);
        tick();
        if (to_hi) m_hi = val; else m_lo = val;
        idle_inputs();
        #1;
        check("mt_hi", bus.hi, m_hi);
        check("mt_lo", bus.lo, m_lo);
        check("mt_busy", {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int          n;
        logic [64:0] r;
        n = (op == OP_MULT || op == OP_MULTU) ? 5 : 10;
        r = ref_result(op, a, b);
        bus.start   = 1'b1;
        bus.hilo_op = op;
        bus.rs_val  = a;
        bus.rt_val  = b;
        bus.md_use  = 1'b1;
        #1;
        check("start_stall", {31'd0, bus.stall}, 32'd0);
        check("start_busy", {31'd0, bus.busy}, 32'd0);
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < n; i++) begin
            // Mix HI/LO users (including blocked mt writes) with unrelated instructions
            bus.md_use = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       bus.hilo_op = OP_MTHI;
                1:       bus.hilo_op = OP_MTLO;
                default: bus.hilo_op = OP_MFLO;
            endcase
            if (!bus.md_use) bus.hilo_op = OP_NONE;
            bus.rs_val = $urandom;
            bus.rt_val = $urandom;
            #1;
            check("run_busy", {31'd0, bus.busy}, 32'd1);
            check("run_stall", {31'd0, bus.stall}, {31'd0, bus.md_use});
            check("run_done", {31'd0, bus.done}, 32'd0);
            check("run_hi", bus.hi, m_hi);
            check("run_lo", bus.lo, m_lo);
            tick();
        end
        idle_inputs();
        bus.md_use  = 1'b1;
        bus.hilo_op = OP_MFLO;
        #1;
        if (r[64]) begin
            m_hi = r[63:32];
            m_lo = r[31:0];
        end
        check("commit_busy", {31'd0, bus.busy}, 32'd0);
        check("commit_done", {31'd0, bus.done}, 32'd1);
        check("commit_stall", {31'd0, bus.stall}, 32'd0);
        check("commit_hi", bus.hi, m_hi);
        check("commit_lo", bus.lo, m_lo);
        tick();
        idle_inputs();
        check("done_pulse", {31'd0, bus.done}, 32'd0);
        check("after_hi", bus.hi, m_hi);
        check("after_lo", bus.lo, m_lo);
    endtask

    initial begin
        logic [3:0] ops [4];
        logic [3:0] op;
        logic [31:0] a, b;
        ops[0] = OP_MULT;
        ops[1] = OP_MULTU;
        ops[2] = OP_DIV;
        ops[3] = OP_DIVU;
        m_hi  = '0;
        m_lo  = '0;
        reset = 1'b0;
        idle_inputs();
        tick();
        tick();
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        reset = 1'b1;
        tick();

        // Reset mid-run discards the pending mult and clears HI/LO immediately
        mt_write(1'b1, 32'hDEAD_BEEF);
        mt_write(1'b0, 32'h1234_5678);
        bus.start   = 1'b1;
        bus.hilo_op = OP_MULT;
        bus.rs_val  = 32'd3;
        bus.rt_val  = 32'd4;
        tick();
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
        #1;
        m_hi = '0;
        m_lo = '0;
        check("midrst_hi", bus.hi, 32'd0);
        check("midrst_lo", bus.lo, 32'd0);
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("midrst_nodone", {31'd0, bus.done}, 32'd0);
            check("midrst_idle", {31'd0, bus.busy}, 32'd0);
            check("midrst_lo_held", bus.lo, 32'd0);
        end

        // Directed arithmetic cases
        run_op(OP_MULT, 32'hFFFF_FFFF, 32'd2);
        check("mult_neg_hi", bus.hi, 32'hFFFF_FFFF);
        check("mult_neg_lo", bus.lo, 32'hFFFF_FFFE);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        check("div_neg_lo", bus.lo, 32'hFFFF_FFFD);
        check("div_neg_hi", bus.hi, 32'hFFFF_FFFF);
        run_op(OP_DIVU, 32'd7, 32'd2);
        check("divu_lo", bus.lo, 32'd3);
        check("divu_hi", bus.hi, 32'd1);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf_lo", bus.lo, 32'h8000_0000);
        check("div_ovf_hi", bus.hi, 32'd0);
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_hi", bus.hi, 32'hFFFF_FFFE);
        check("multu_lo", bus.lo, 32'd1);
        mt_write(1'b1, 32'h11);
        mt_write(1'b0, 32'h22);
        run_op(OP_DIVU, 32'd100, 32'd0);
        check("dz_hi", bus.hi, 32'h11);
        check("dz_lo", bus.lo, 32'h22);

        // Randomized operations interleaved with mt writes
        for (int k = 0; k < 16; k++) begin
            op = ops[$urandom_range(0, 3)];
            a  = $urandom;
            b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
            if ($urandom_range(0, 2) == 0) mt_write(1'($urandom_range(0, 1)), $urandom);
            run_op(op, a, b);
        end

`ifdef MDU_CANCEL_EN
        // Cancel at busy cycle 4 aborts without commit
        mt_write(1'b1, 32'hAAAA_0001);
        mt_write(1'b0, 32'hBBBB_0002);
        bus.start   = 1'b1;
        bus.hilo_op = OP_DIV;
        bus.rs_val  = 32'd50;
        bus.rt_val  = 32'd7;
        tick();
        idle_inputs();
        tick();
        tick();
        tick();
        check("cancel_busy_before", {31'd0, bus.busy}, 32'd1);
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        check("cancel_busy", {31'd0, bus.busy}, 32'd0);
        check("cancel_done", {31'd0, bus.done}, 32'd0);
        check("cancel_hi", bus.hi, m_hi);
        check("cancel_lo", bus.lo, m_lo);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("cancel_nodone", {31'd0, bus.done}, 32'd0);
            check("cancel_lo_held", bus.lo, m_lo);
        end
        // Cancel coinciding with start blocks the start
        bus.start   = 1'b1;
        bus.hilo_op = OP_MULT;
        bus.rs_val  = 32'd9;
        bus.rt_val  = 32'd9;
        bus.cancel  = 1'b1;
        tick();
        idle_inputs();
        check("cancel_start_busy", {31'd0, bus.busy}, 32'd0);
        for (int i = 0; i < 7; i++) tick();
        check("cancel_start_lo", bus.lo, m_lo);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
